// File: rtl/sdram_pkg.sv
// Shared SDRAM arbiter definitions: word/address widths, transfer-size field and fill FSM states.
package sdram_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned SDRAM_ADDR_W = 25;
    localparam int unsigned MAX_TRANS    = 64;
    localparam int unsigned TRANS_W      = $clog2(MAX_TRANS);

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_REQ,
        FILL_DELIVER
    } fill_state_t;

endpackage

// File: rtl/fill_line_buffer.sv
// Line buffer for one cache line: indexed single-word writes, whole line read out flat.
module fill_line_buffer
    import sdram_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    localparam int unsigned IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [WORD_W-1:0]            wr_data,
    output logic [LINE_WORDS*WORD_W-1:0] line
);

    logic [WORD_W-1:0] mem_q [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LINE_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < int'(LINE_WORDS); g++) begin : g_flat
        assign line[g*WORD_W +: WORD_W] = mem_q[g];
    end

endmodule

// File: rtl/cache_line_fill.sv
// Cache miss handler: issues one LINE_WORDS burst read per miss, buffers the words and
// returns the full line to the cache with a valid/ack handshake.
module cache_line_fill
    import sdram_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned ADDR_W     = sdram_pkg::SDRAM_ADDR_W,
    parameter int unsigned TRANS_W    = sdram_pkg::TRANS_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         miss_valid,
    input  logic [ADDR_W-1:0]            miss_addr,
    output logic                         miss_ready,
    output logic                         fill_valid,
    output logic [ADDR_W-1:0]            fill_addr,
    output logic [LINE_WORDS*WORD_W-1:0] fill_line,
    input  logic                         fill_ack,
    output logic                         fill_err,
    output logic                         readReq,
    output logic [ADDR_W-1:0]            rd_addr,
    output logic [TRANS_W-1:0]           transSize,
    input  logic                         readValid,
    input  logic [WORD_W-1:0]            readData,
    input  logic                         doneRead
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);

    fill_state_t      state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             wr_en;

    assign transSize  = TRANS_W'(LINE_WORDS);
    assign wr_en      = (state_q == FILL_REQ) && readValid && (count_q < FULL);
    // Count including a word captured this cycle, so a final word alongside doneRead is seen.
    assign count_next = wr_en ? count_q + CNT_W'(1) : count_q;

    fill_line_buffer #(
        .LINE_WORDS (LINE_WORDS)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_idx  (count_q[IDX_W-1:0]),
        .wr_data (readData),
        .line    (fill_line)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL_IDLE;
            miss_ready <= 1'b1;
            readReq    <= 1'b0;
            fill_valid <= 1'b0;
            fill_err   <= 1'b0;
            rd_addr    <= '0;
            fill_addr  <= '0;
            count_q    <= '0;
        end else begin
            unique case (state_q)
                FILL_IDLE: begin
                    if (miss_valid) begin
                        state_q    <= FILL_REQ;
                        miss_ready <= 1'b0;
                        readReq    <= 1'b1;
                        rd_addr    <= miss_addr & LINE_MASK;
                        count_q    <= '0;
                    end
                end
                FILL_REQ: begin
                    count_q <= count_next;
                    if (readValid && !wr_en) begin
                        fill_err <= 1'b1;
                    end
                    if (doneRead) begin
                        if (count_next != FULL) begin
                            fill_err <= 1'b1;
                        end
                        state_q    <= FILL_DELIVER;
                        readReq    <= 1'b0;
                        fill_valid <= 1'b1;
                        fill_addr  <= rd_addr;
                    end
                end
                FILL_DELIVER: begin
                    if (fill_ack) begin
                        state_q    <= FILL_IDLE;
                        fill_valid <= 1'b0;
                        miss_ready <= 1'b1;
                    end
                end
                default: state_q <= FILL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill with LINE_WORDS=8: fills, gaps, short/over bursts, reset.
module tb_cache_line_fill;

    localparam int LW = 8;
    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          miss_valid = 1'b0;
    logic [AW-1:0] miss_addr = '0;
    logic          miss_ready;
    logic          fill_valid;
    logic [AW-1:0] fill_addr;
    logic [LW*32-1:0] fill_line;
    logic          fill_ack = 1'b0;
    logic          fill_err;
    logic          readReq;
    logic [AW-1:0] rd_addr;
    logic [5:0]    transSize;
    logic          readValid = 1'b0;
    logic [31:0]   readData = '0;
    logic          doneRead = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    logic [LW*32-1:0] exp_line;

    always #5 clk = ~clk;

    cache_line_fill u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .miss_ready (miss_ready),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_line  (fill_line),
        .fill_ack   (fill_ack),
        .fill_err   (fill_err),
        .readReq    (readReq),
        .rd_addr    (rd_addr),
        .transSize  (transSize),
        .readValid  (readValid),
        .readData   (readData),
        .doneRead   (doneRead)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic issue_miss(input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr);
        miss_valid = 1'b1;
        miss_addr  = addr;
        tick();
        miss_valid = 1'b0;
        n_vec++;
        if (miss_ready !== 1'b0 || readReq !== 1'b1 || rd_addr !== exp_addr) begin
            $display("FAIL miss_accept: ready=%b req=%b rd_addr=%h, required 0 1 %h",
                     miss_ready, readReq, rd_addr, exp_addr);
            n_err++;
        end
    endtask

    // Sends n words base+i; the last one carries doneRead when with_done is set.
    task automatic send_words(input int n, input logic [31:0] base, input int max_gap,
                              input bit with_done);
        for (int i = 0; i < n; i++) begin
            readValid = 1'b1;
            readData  = base + 32'(i);
            if (with_done && i == n - 1) doneRead = 1'b1;
            tick();
            readValid = 1'b0;
            doneRead  = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    task automatic finish_burst();
        doneRead = 1'b1;
        tick();
        doneRead = 1'b0;
    endtask

    task automatic build_line(input logic [31:0] base, input int n);
        exp_line = '0;
        for (int i = 0; i < n; i++) exp_line[i*32 +: 32] = base + 32'(i);
    endtask

    task automatic check_deliver(input string name, input logic [AW-1:0] exp_addr,
                                 input logic exp_err, input int nwords);
        logic [LW*32-1:0] mask;
        mask = '0;
        for (int i = 0; i < nwords; i++) mask[i*32 +: 32] = '1;
        n_vec++;
        if (fill_valid !== 1'b1 || readReq !== 1'b0 || fill_addr !== exp_addr) begin
            $display("FAIL %s_ctl: valid=%b req=%b fill_addr=%h, required 1 0 %h",
                     name, fill_valid, readReq, fill_addr, exp_addr);
            n_err++;
        end
        n_vec++;
        if ((fill_line & mask) !== (exp_line & mask)) begin
            $display("FAIL %s_data: got %h, required %h", name, fill_line & mask,
                     exp_line & mask);
            n_err++;
        end
        n_vec++;
        if (fill_err !== exp_err) begin
            $display("FAIL %s_err: got %b, required %b", name, fill_err, exp_err);
            n_err++;
        end
    endtask

    task automatic ack_fill(input string name);
        fill_ack = 1'b1;
        tick();
        fill_ack = 1'b0;
        n_vec++;
        if (miss_ready !== 1'b1 || fill_valid !== 1'b0) begin
            $display("FAIL %s_ack: ready=%b valid=%b, required 1 0", name, miss_ready,
                     fill_valid);
            n_err++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (miss_ready !== 1'b1 || readReq !== 1'b0 || fill_valid !== 1'b0 ||
            fill_err !== 1'b0 || rd_addr !== '0 || fill_addr !== '0 || fill_line !== '0) begin
            $display("FAIL reset: ready=%b req=%b valid=%b err=%b rd=%h fa=%h line=%h",
                     miss_ready, readReq, fill_valid, fill_err, rd_addr, fill_addr, fill_line);
            n_err++;
        end
        n_vec++;
        if (transSize !== 6'd8) begin
            $display("FAIL trans_size: got %0d, required 8", transSize);
            n_err++;
        end
    endtask

    task automatic test_basic();
        issue_miss(25'h000013, 25'h000010);
        send_words(8, 32'hA0, 0, 1'b0);
        n_vec++;
        if (readReq !== 1'b1 || fill_valid !== 1'b0) begin
            $display("FAIL basic_hold_req: req=%b valid=%b, required 1 0", readReq, fill_valid);
            n_err++;
        end
        finish_burst();
        build_line(32'hA0, 8);
        check_deliver("basic", 25'h000010, 1'b0, 8);
        ack_fill("basic");
    endtask

    task automatic test_gapped();
        issue_miss(25'h1234567, 25'h1234560);
        send_words(8, 32'h1000, 5, 1'b0);
        finish_burst();
        build_line(32'h1000, 8);
        check_deliver("gapped", 25'h1234560, 1'b0, 8);
        for (int c = 0; c < 10; c++) begin
            // Misses while busy must not disturb the held line.
            miss_valid = (c == 3);
            miss_addr  = 25'h0000F0;
            tick();
            miss_valid = 1'b0;
            n_vec++;
            if (fill_valid !== 1'b1 || miss_ready !== 1'b0 || fill_line !== exp_line ||
                fill_addr !== 25'h1234560) begin
                $display("FAIL gapped_stall_%0d: valid=%b ready=%b addr=%h line=%h", c,
                         fill_valid, miss_ready, fill_addr, fill_line);
                n_err++;
            end
        end
        ack_fill("gapped");
    endtask

    task automatic test_back_to_back_done();
        issue_miss(25'h00002B, 25'h000028);
        send_words(8, 32'hD0, 0, 1'b1);
        build_line(32'hD0, 8);
        check_deliver("same_cycle_done", 25'h000028, 1'b0, 8);
        ack_fill("same_cycle_done");
    endtask

    task automatic test_short();
        issue_miss(25'h000044, 25'h000040);
        send_words(5, 32'hB0, 0, 1'b0);
        finish_burst();
        build_line(32'hB0, 5);
        check_deliver("short", 25'h000040, 1'b1, 5);
        ack_fill("short");
    endtask

    task automatic test_overrun();
        do_reset();
        issue_miss(25'h000087, 25'h000080);
        send_words(9, 32'hC0, 0, 1'b0);
        n_vec++;
        if (fill_err !== 1'b1 || readReq !== 1'b1) begin
            $display("FAIL overrun_flag: err=%b req=%b, required 1 1", fill_err, readReq);
            n_err++;
        end
        finish_burst();
        build_line(32'hC0, 8);
        check_deliver("overrun", 25'h000080, 1'b1, 8);
        ack_fill("overrun");
    endtask

    task automatic test_midburst_reset();
        do_reset();
        issue_miss(25'h000100, 25'h000100);
        miss_valid = 1'b1;
        miss_addr  = 25'h000200;
        tick();
        miss_valid = 1'b0;
        n_vec++;
        if (rd_addr !== 25'h000100 || readReq !== 1'b1 || miss_ready !== 1'b0) begin
            $display("FAIL busy_miss: rd_addr=%h req=%b ready=%b, required 000100 1 0",
                     rd_addr, readReq, miss_ready);
            n_err++;
        end
        send_words(3, 32'hE0, 0, 1'b0);
        do_reset();
        n_vec++;
        if (miss_ready !== 1'b1 || readReq !== 1'b0 || fill_valid !== 1'b0 ||
            fill_err !== 1'b0 || rd_addr !== '0 || fill_addr !== '0 || fill_line !== '0) begin
            $display("FAIL midburst_reset: ready=%b req=%b valid=%b err=%b rd=%h line=%h",
                     miss_ready, readReq, fill_valid, fill_err, rd_addr, fill_line);
            n_err++;
        end
        issue_miss(25'h000055, 25'h000050);
        send_words(8, 32'hF0, 0, 1'b0);
        finish_burst();
        build_line(32'hF0, 8);
        check_deliver("after_reset", 25'h000050, 1'b0, 8);
        ack_fill("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back_done();
        test_short();
        test_overrun();
        test_midburst_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
